// File: rtl/router_pkt_tx_if.sv
// Router input link: byte stream toward the router plus its stall and
// parity-error feedback.
//   pkt_valid  tx -> router  high for header/payload bytes, low for parity
//   data_out   tx -> router  byte on the link
//   busy       router -> tx  stall; no byte moves on a busy cycle
//   err_in     router -> tx  router parity error flag
interface router_pkt_tx_if;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       busy;
    logic       err_in;

    modport master (output pkt_valid, output data_out, input busy, input err_in);
    modport slave  (input pkt_valid, input data_out, output busy, output err_in);
endinterface

// File: rtl/router_pkt_tx.sv
// Packet source for a router input port. On an accepted start it sends a
// header {pay_len, dest_addr}, pay_len payload bytes popped from a
// first-word-fall-through FIFO, then an XOR parity byte, followed by a short
// idle gap. Honours the router busy stall and flags long stalls.
//   clk, rst             clock, asynchronous active-low reset
//   start/dest_addr/pay_len  send request (sampled in IDLE only)
//   pay_data/pay_empty/pay_rd  payload FIFO head, empty flag, pop
//   rtr                  router link (pkt_valid, data_out, busy, err_in)
//   tx_active            not idle
//   done                 pulse on entry to the gap
//   bad_req              pulse after a rejected start
//   underrun, timeout    sticky, cleared by an accepted start
//   pkt_err              err_in sampled at the end of the gap
module router_pkt_tx #(
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pay_len,
    input  logic [7:0] pay_data,
    input  logic       pay_empty,
    output logic       pay_rd,
    output logic       tx_active,
    output logic       done,
    output logic       bad_req,
    output logic       underrun,
    output logic       timeout,
    output logic       pkt_err,
    router_pkt_tx_if.master rtr
);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic [7:0]    parity_q, parity_d;
    logic [5:0]    rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    busy_cnt_q, busy_cnt_d;
    logic          done_q, done_d;
    logic          bad_req_q, bad_req_d;
    logic          underrun_q, underrun_d;
    logic          timeout_q, timeout_d;
    logic          pkt_err_q, pkt_err_d;
    logic [7:0]    pay_byte;
    logic          sending;

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        parity_d   = parity_q;
        rem_d      = rem_q;
        gap_d      = gap_q;
        busy_cnt_d = busy_cnt_q;
        done_d     = 1'b0;
        bad_req_d  = 1'b0;
        underrun_d = underrun_q;
        timeout_d  = timeout_q;
        pkt_err_d  = pkt_err_q;
        pay_rd     = 1'b0;
        // An empty FIFO substitutes 0x00 so the packet keeps its length.
        pay_byte   = pay_empty ? 8'h00 : pay_data;
        sending    = (state_q == HEADER) || (state_q == PAYLOAD) || (state_q == PARITY);

        // Consecutive-stall counter, saturating; only runs while a byte is pending.
        if (sending && rtr.busy) begin
            busy_cnt_d = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;
            if (busy_cnt_q == 8'(BUSY_TIMEOUT - 1)) timeout_d = 1'b1;
        end else begin
            busy_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dest_addr != 2'd3 && pay_len != 6'd0) begin
                        state_d    = HEADER;
                        data_d     = {pay_len, dest_addr};
                        valid_d    = 1'b1;
                        parity_d   = {pay_len, dest_addr};
                        rem_d      = pay_len;
                        underrun_d = 1'b0;
                        timeout_d  = 1'b0;
                    end else begin
                        bad_req_d = 1'b1;
                    end
                end
            end
            HEADER, PAYLOAD: begin
                if (!rtr.busy) begin
                    if (rem_q != 6'd0) begin
                        pay_rd   = !pay_empty;
                        data_d   = pay_byte;
                        parity_d = parity_q ^ pay_byte;
                        rem_d    = rem_q - 6'd1;
                        state_d  = PAYLOAD;
                        if (pay_empty) underrun_d = 1'b1;
                    end else begin
                        data_d  = parity_q;
                        valid_d = 1'b0;
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!rtr.busy) begin
                    state_d = GAP;
                    data_d  = '0;
                    done_d  = 1'b1;
                    gap_d   = GW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    pkt_err_d = rtr.err_in;
                    state_d   = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            parity_q   <= '0;
            rem_q      <= '0;
            gap_q      <= '0;
            busy_cnt_q <= '0;
            done_q     <= 1'b0;
            bad_req_q  <= 1'b0;
            underrun_q <= 1'b0;
            timeout_q  <= 1'b0;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            parity_q   <= parity_d;
            rem_q      <= rem_d;
            gap_q      <= gap_d;
            busy_cnt_q <= busy_cnt_d;
            done_q     <= done_d;
            bad_req_q  <= bad_req_d;
            underrun_q <= underrun_d;
            timeout_q  <= timeout_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    assign rtr.pkt_valid = valid_q;
    assign rtr.data_out  = data_q;
    assign tx_active     = (state_q != IDLE);
    assign done          = done_q;
    assign bad_req       = bad_req_q;
    assign underrun      = underrun_q;
    assign timeout       = timeout_q;
    assign pkt_err       = pkt_err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
module tb_router_pkt_tx;
    localparam int unsigned GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] dest_addr = '0;
    logic [5:0] pay_len = '0;
    logic [7:0] pay_data = '0;
    logic       pay_empty = 1'b1;
    logic       pay_rd, tx_active, done, bad_req, underrun, timeout, pkt_err;

    router_pkt_tx_if rif();

    router_pkt_tx #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
        .pay_data(pay_data), .pay_empty(pay_empty), .pay_rd(pay_rd), .tx_active(tx_active),
        .done(done), .bad_req(bad_req), .underrun(underrun), .timeout(timeout),
        .pkt_err(pkt_err), .rtr(rif.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [7:0] fifo[$];

    task automatic refresh();
        pay_empty = (fifo.size() == 0);
        pay_data  = pay_empty ? 8'($urandom) : fifo[0];
    endtask

    // Reference: the packet is header, len bytes (FIFO contents, 0x00 once the
    // FIFO runs dry), then the XOR of everything before it.
    task automatic send_pkt(input logic [1:0] addr, input int unsigned len,
                            input int unsigned hold_idx, input int unsigned hold_n,
                            input bit rand_busy, input bit err, input string name);
        logic [7:0] exp[$];
        logic [7:0] par;
        logic [7:0] b;
        logic [5:0] l6;
        int unsigned nfifo, hold;
        bit tout_exp, rd;
        nfifo = fifo.size();
        l6 = len[5:0];
        tout_exp = 1'b0;
        exp.push_back({l6, addr});
        par = exp[0];
        for (int unsigned i = 0; i < len; i++) begin
            b = (i < nfifo) ? fifo[i] : 8'h00;
            exp.push_back(b);
            par ^= b;
        end
        exp.push_back(par);
        refresh();
        start = 1'b1; dest_addr = addr; pay_len = l6;
        @(posedge clk); #1;
        start = 1'b0; dest_addr = 2'($urandom); pay_len = 6'($urandom);
        for (int unsigned i = 0; i <= len + 1; i++) begin
            hold = (i == hold_idx) ? hold_n : (rand_busy ? $urandom_range(0, 3) : 0);
            for (int unsigned h = 0; h < hold; h++) begin
                rif.busy = 1'b1;
                @(negedge clk);
                checks++; if (rif.data_out !== exp[i]) begin failures++; $display("FAIL %s held data_out byte %0d got=%h exp=%h", name, i, rif.data_out, exp[i]); end
                checks++; if (rif.pkt_valid !== (i <= len)) begin failures++; $display("FAIL %s held pkt_valid byte %0d got=%b exp=%b", name, i, rif.pkt_valid, (i <= len)); end
                checks++; if (pay_rd !== 1'b0) begin failures++; $display("FAIL %s pay_rd while busy got=%b exp=0", name, pay_rd); end
                checks++; if (timeout !== tout_exp) begin failures++; $display("FAIL %s timeout busy cycle %0d got=%b exp=%b", name, h, timeout, tout_exp); end
                @(posedge clk);
                if (h + 1 >= 255) tout_exp = 1'b1;
                #1;
            end
            rif.busy = 1'b0;
            @(negedge clk);
            checks++; if (rif.data_out !== exp[i]) begin failures++; $display("FAIL %s data_out byte %0d got=%h exp=%h", name, i, rif.data_out, exp[i]); end
            checks++; if (rif.pkt_valid !== (i <= len)) begin failures++; $display("FAIL %s pkt_valid byte %0d got=%b exp=%b", name, i, rif.pkt_valid, (i <= len)); end
            checks++; if (pay_rd !== (i < len && i < nfifo)) begin failures++; $display("FAIL %s pay_rd byte %0d got=%b exp=%b", name, i, pay_rd, (i < len && i < nfifo)); end
            checks++; if (tx_active !== 1'b1) begin failures++; $display("FAIL %s tx_active byte %0d got=%b exp=1", name, i, tx_active); end
            checks++; if (timeout !== tout_exp) begin failures++; $display("FAIL %s timeout byte %0d got=%b exp=%b", name, i, timeout, tout_exp); end
            rd = pay_rd;
            @(posedge clk); #1;
            if (rd && fifo.size() > 0) void'(fifo.pop_front());
            refresh();
        end
        // First gap cycle; a valid start here must be ignored.
        rif.err_in = err;
        start = 1'b1; dest_addr = 2'd1; pay_len = 6'd5;
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL %s done pulse got=%b exp=1", name, done); end
        checks++; if (rif.pkt_valid !== 1'b0 || rif.data_out !== 8'h00) begin failures++; $display("FAIL %s gap link got=%b/%h exp=0/00", name, rif.pkt_valid, rif.data_out); end
        checks++; if (underrun !== (len > nfifo)) begin failures++; $display("FAIL %s underrun got=%b exp=%b", name, underrun, (len > nfifo)); end
        for (int unsigned g = 1; g < GAP; g++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (done !== 1'b0 || tx_active !== 1'b1) begin failures++; $display("FAIL %s gap hold done/tx_active got=%b/%b exp=0/1", name, done, tx_active); end
        end
        @(posedge clk); #1;
        start = 1'b0; rif.err_in = 1'($urandom);
        @(negedge clk);
        checks++; if (tx_active !== 1'b0) begin failures++; $display("FAIL %s back to idle tx_active got=%b exp=0", name, tx_active); end
        checks++; if (pkt_err !== err) begin failures++; $display("FAIL %s pkt_err got=%b exp=%b", name, pkt_err, err); end
        checks++; if (timeout !== tout_exp || underrun !== (len > nfifo)) begin failures++; $display("FAIL %s sticky flags idle got=%b/%b exp=%b/%b", name, timeout, underrun, tout_exp, (len > nfifo)); end
        fifo.delete();
        refresh();
    endtask

    task automatic test_reset();
        rst = 1'b0; rif.busy = 1'b0; rif.err_in = 1'b0;
        refresh();
        #12;
        checks++; if ({rif.pkt_valid, rif.data_out, done, bad_req, underrun, timeout, pkt_err, tx_active} !== '0) begin failures++; $display("FAIL reset outputs got=%b exp=0", {rif.pkt_valid, rif.data_out, done, bad_req, underrun, timeout, pkt_err, tx_active}); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_basic();
        fifo = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 3, 999, 0, 1'b0, 1'b0, "T1_basic");
    endtask

    task automatic test_busy_stall();
        fifo = '{8'h11, 8'h22, 8'h33};
        send_pkt(2'd1, 3, 2, 4, 1'b0, 1'b0, "T2_stall");
    endtask

    task automatic test_bad_req();
        logic [1:0] a[2];
        logic [5:0] l[2];
        a = '{2'd3, 2'd0}; l = '{6'd5, 6'd0};
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; dest_addr = a[k]; pay_len = l[k];
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            checks++; if (bad_req !== 1'b1 || tx_active !== 1'b0) begin failures++; $display("FAIL T3_bad_req %0d bad_req/tx_active got=%b/%b exp=1/0", k, bad_req, tx_active); end
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (bad_req !== 1'b0 || tx_active !== 1'b0) begin failures++; $display("FAIL T3_bad_req %0d pulse end got=%b/%b exp=0/0", k, bad_req, tx_active); end
        end
    endtask

    task automatic test_underrun();
        fifo = '{8'hAA, 8'h55};
        send_pkt(2'd0, 4, 999, 0, 1'b0, 1'b0, "T4_underrun");
    endtask

    task automatic test_reset_mid();
        fifo.delete();
        for (int i = 0; i < 10; i++) fifo.push_back(8'($urandom));
        refresh();
        start = 1'b1; dest_addr = 2'd2; pay_len = 6'd10;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            void'(fifo.pop_front()); refresh();
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({rif.pkt_valid, rif.data_out, done, bad_req, underrun, timeout, pkt_err, tx_active, pay_rd} !== '0) begin failures++; $display("FAIL T5_reset_mid outputs got=%b exp=0", {rif.pkt_valid, rif.data_out, done, bad_req, underrun, timeout, pkt_err, tx_active, pay_rd}); end
        rst = 1'b1;
        fifo.delete();
        for (int i = 0; i < 6; i++) fifo.push_back(8'($urandom));
        send_pkt(2'd2, 6, 999, 0, 1'b0, 1'b0, "T5_fresh");
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 5; i++) fifo.push_back(8'($urandom));
        send_pkt(2'd2, 5, 0, 300, 1'b0, 1'b1, "T6_timeout");
    endtask

    task automatic test_random();
        int unsigned len;
        for (int p = 0; p < 15; p++) begin
            len = $urandom_range(1, 63);
            fifo.delete();
            if ($urandom_range(0, 3) == 0) begin
                for (int unsigned i = 0; i < $urandom_range(0, len - 1); i++) fifo.push_back(8'($urandom));
            end else begin
                for (int unsigned i = 0; i < len; i++) fifo.push_back(8'($urandom));
            end
            send_pkt(2'($urandom_range(0, 2)), len, 999, 0, 1'b1, 1'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 2; i++) fifo.push_back(8'($urandom));
            send_pkt(2'd0, 2, 999, 0, 1'b0, 1'b0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_bad_req();
        test_underrun();
        test_reset_mid();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
